// File: rtl/uart_pkg.sv
// uart_pkg: state encoding and shared constants for the UART receiver and transmitter
// Optional feature macro: UART_RX_PARITY_EN adds the PARITY receive state.
package uart_pkg;

    localparam int DATA_BITS        = 8;
    localparam int CLKS_PER_BIT_DEF = 434;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef UART_RX_PARITY_EN
        PARITY,
`endif
        STOP,
        BREAK
    } rx_state_t;

endpackage

// File: rtl/uart_rx_sync.sv
// uart_rx_sync: two-flop synchronizer for the asynchronous serial line, resets to idle-high
module uart_rx_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    // shift the raw line through two flops to settle metastability
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) {q, meta} <= 2'b11;
        else        {q, meta} <= {meta, d};
    end

endmodule

// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver with mid-bit sampling, glitch rejection and break handling
// Optional feature macro: UART_RX_PARITY_EN enables an even parity bit (8E1 frames).
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] rxdata,
    output logic                 rxfinish,
    output logic                 frame_err
);

    localparam int             CW   = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0]  HALF = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0]  LAST = CW'(CLKS_PER_BIT - 1);
`ifdef UART_RX_PARITY_EN
    localparam rx_state_t      AFTER_DATA = PARITY;
`else
    localparam rx_state_t      AFTER_DATA = STOP;
`endif

    rx_state_t            state, state_n;
    logic                 rx_s;
    logic [CW-1:0]        cnt;
    logic [2:0]           bit_cnt;
    logic [DATA_BITS-1:0] shift;
    logic                 tick_half, tick_full, frame_ok, fin_d, err_d;

    uart_rx_sync u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (rx),
        .q     (rx_s)
    );

    assign tick_half = cnt == HALF;
    assign tick_full = cnt == LAST;

`ifdef UART_RX_PARITY_EN
    logic par_bit;

    // capture the parity bit at its mid-point
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                          par_bit <= 1'b0;
        else if (state == PARITY && tick_full) par_bit <= rx_s;
    end

    assign frame_ok = rx_s && (par_bit == ^shift);
`else
    assign frame_ok = rx_s;
`endif

    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_n;
    end

    // next-state: start detect, half-bit start check, mid-bit data, stop verdict, break wait
    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (!rx_s)     state_n = START;
            START:   if (tick_half) state_n = rx_s ? IDLE : DATA;
            DATA:    if (tick_full && bit_cnt == 3'(DATA_BITS - 1)) state_n = AFTER_DATA;
`ifdef UART_RX_PARITY_EN
            PARITY:  if (tick_full) state_n = STOP;
`endif
            STOP:    if (tick_full) state_n = rx_s ? IDLE : BREAK;
            BREAK:   if (rx_s)      state_n = IDLE;
            default:                state_n = IDLE;
        endcase
    end

    // output decode: the stop-bit verdict yields exactly one of the two pulses
    always_comb begin
        fin_d = state == STOP && tick_full && frame_ok;
        err_d = state == STOP && tick_full && !frame_ok;
    end

    // datapath: bit timing, bit count, LSB-first shift and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt       <= '0;
            bit_cnt   <= '0;
            shift     <= '0;
            rxdata    <= '0;
            rxfinish  <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            cnt <= (state != state_n || tick_full || state == IDLE || state == BREAK) ? '0 : cnt + 1'b1;
            if (state == IDLE)
                bit_cnt <= '0;
            else if (state == DATA && tick_full)
                bit_cnt <= bit_cnt + 3'd1;
            if (state == DATA && tick_full)
                shift <= {rx_s, shift[DATA_BITS-1:1]};
            if (fin_d)
                rxdata <= shift;
            rxfinish  <= fin_d;
            frame_err <= err_d;
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: table-driven frame vectors plus directed glitch, back-to-back and reset sequences
module tb_uart_rx;
    import uart_pkg::*;

    localparam int CPB = 8;
`ifdef UART_RX_PARITY_EN
    localparam int LAT_NOM = 86;
`else
    localparam int LAT_NOM = 78;
`endif

    typedef struct {
        logic [7:0] data;
        logic       stop;
        logic       bad_par;
        logic [7:0] exp_data;
        int         exp_fin;
        int         exp_err;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx = 1'b1;
    logic [7:0] rxdata;
    logic       rxfinish, frame_err;

    int         checks = 0;
    int         fails = 0;
    int         fin_cnt = 0;
    int         err_cnt = 0;
    int         overlap = 0;
    time        t_fin_last = 0;
    time        t_fall = 0;
    logic [7:0] fin_q[$];
    vec_t       vecs[$];

    uart_rx #(.CLKS_PER_BIT(CPB)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rx        (rx),
        .rxdata    (rxdata),
        .rxfinish  (rxfinish),
        .frame_err (frame_err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rxfinish) begin
            fin_cnt++;
            fin_q.push_back(rxdata);
            t_fin_last = $time;
        end
        if (frame_err) err_cnt++;
        if (rxfinish && frame_err) overlap++;
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_range(input string name, input int act, input int lo, input int hi);
        checks++;
        if (act < lo || act > hi) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
        end
    endtask

    task automatic send_bit(input logic b);
        rx = b;
        repeat (CPB) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop, input logic bad_par);
        t_fall = $time;
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
`ifdef UART_RX_PARITY_EN
        send_bit(^d ^ bad_par);
`else
        if (bad_par) $display("note: parity ignored in 8N1 build");
`endif
        send_bit(stop);
    endtask

    initial begin
        int f0, e0, q0, lat;
        vecs.push_back('{8'hA5, 1'b1, 1'b0, 8'hA5, 1, 0});
        vecs.push_back('{8'h3C, 1'b0, 1'b0, 8'hA5, 0, 1});
        vecs.push_back('{8'h11, 1'b1, 1'b0, 8'h11, 1, 0});
        vecs.push_back('{8'h00, 1'b1, 1'b0, 8'h00, 1, 0});
        vecs.push_back('{8'hFF, 1'b1, 1'b0, 8'hFF, 1, 0});
`ifdef UART_RX_PARITY_EN
        vecs.push_back('{8'h01, 1'b1, 1'b1, 8'hFF, 0, 1});
        vecs.push_back('{8'h01, 1'b1, 1'b0, 8'h01, 1, 0});
`endif

        repeat (3) @(negedge clk);
        check("reset_rxdata", rxdata, 8'h00);
        check("reset_rxfinish", rxfinish, 0);
        check("reset_frame_err", frame_err, 0);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);

        foreach (vecs[k]) begin
            f0 = fin_cnt;
            e0 = err_cnt;
            send_frame(vecs[k].data, vecs[k].stop, vecs[k].bad_par);
            if (!vecs[k].stop) begin
                rx = 1'b0;
                repeat (20) @(negedge clk);
            end
            rx = 1'b1;
            repeat (2 * CPB) @(negedge clk);
            check($sformatf("vec%0d_rxfinish_count", k), fin_cnt - f0, vecs[k].exp_fin);
            check($sformatf("vec%0d_frame_err_count", k), err_cnt - e0, vecs[k].exp_err);
            check($sformatf("vec%0d_rxdata", k), rxdata, vecs[k].exp_data);
            if (vecs[k].exp_fin == 1) begin
                lat = int'((t_fin_last - t_fall) / 10);
                check_range($sformatf("vec%0d_latency", k), lat, LAT_NOM - 1, LAT_NOM + 2);
            end
        end

        f0 = fin_cnt;
        e0 = err_cnt;
        rx = 1'b0;
        repeat (2) @(negedge clk);
        rx = 1'b1;
        repeat (3 * CPB) @(negedge clk);
        check("glitch_rxfinish_count", fin_cnt - f0, 0);
        check("glitch_frame_err_count", err_cnt - e0, 0);
        check("glitch_state_idle", int'(dut.state), int'(IDLE));

        q0 = fin_q.size();
        send_frame(8'h03, 1'b1, 1'b0);
        send_frame(8'h07, 1'b1, 1'b0);
        send_frame(8'h01, 1'b1, 1'b0);
        repeat (2 * CPB) @(negedge clk);
        check("b2b_rxfinish_count", fin_q.size() - q0, 3);
        if (fin_q.size() - q0 == 3) begin
            check("b2b_byte0", fin_q[q0], 8'h03);
            check("b2b_byte1", fin_q[q0+1], 8'h07);
            check("b2b_byte2", fin_q[q0+2], 8'h01);
        end

        f0 = fin_cnt;
        e0 = err_cnt;
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(1'b1);
        rx = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check("midreset_rxdata", rxdata, 8'h00);
        check("midreset_rxfinish", rxfinish, 0);
        check("midreset_frame_err", frame_err, 0);
        rst_n = 1'b1;
        repeat (5 * CPB) @(negedge clk);
        send_frame(8'h5A, 1'b1, 1'b0);
        repeat (2 * CPB) @(negedge clk);
        check("midreset_rxfinish_count", fin_cnt - f0, 1);
        check("midreset_frame_err_count", err_cnt - e0, 0);
        check("midreset_rxdata_after", rxdata, 8'h5A);

        check("no_overlap_pulses", overlap, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
